// File: rtl/vfifo_pkg.sv
// vfifo_pkg: shared sizing helpers for the single-clock FIFO controller.
package vfifo_pkg;
  function automatic int ptr_w(int aw);
    return aw + 1;
  endfunction
  function automatic int depth(int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/vfifo_ptr_cnt.sv
// vfifo_ptr_cnt: wrap-bit binary pointer with increment and synchronous clear.
module vfifo_ptr_cnt import vfifo_pkg::*; #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         clr,
  output logic [ptr_w(ADDR_WIDTH)-1:0] ptr,
  output logic [ptr_w(ADDR_WIDTH)-1:0] ptr_next
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  always_comb ptr_next = clr ? '0 : ptr + PW'(inc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else ptr <= ptr_next;
endmodule

// File: rtl/vfifo_sc_fifo_ctrl.sv
// vfifo_sc_fifo_ctrl: single-clock FIFO controller driving a dual-port RAM
// with first-word-fall-through reads via a registered read address.
module vfifo_sc_fifo_ctrl import vfifo_pkg::*; #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wadr,
  output logic [ADDR_WIDTH-1:0] ram_radr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(depth(ADDR_WIDTH));
  localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE = PW'(AEMPTY_THRESH);
  logic push_ok, pop_ok;
  logic [PW-1:0] wr_ptr, wr_next, rd_ptr, rd_next, fill_next;
  logic unused_bits;
  vfifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(push_ok), .clr(clear), .ptr(wr_ptr), .ptr_next(wr_next)
  );
  vfifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(pop_ok), .clr(clear), .ptr(rd_ptr), .ptr_next(rd_next)
  );
  always_comb begin
    push_ok     = wr_en & (~full | rd_en);
    pop_ok      = rd_en & ~empty;
    ram_we      = push_ok & ~clear & rst_n;
    ram_wadr    = wr_ptr[ADDR_WIDTH-1:0];
    ram_radr    = rd_next[ADDR_WIDTH-1:0];
    fill_next   = clear ? '0 : fill + PW'(push_ok) - PW'(pop_ok);
    unused_bits = ^{wr_next, wr_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH]};
  end
  // Flags are derived from the next fill so they stay coherent with fill.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      fill         <= fill_next;
      full         <= fill_next == DEPTH;
      empty        <= fill_next == '0;
      almost_full  <= fill_next >= AF;
      almost_empty <= fill_next <= AE;
      overflow     <= ~clear & (overflow | (wr_en & ~push_ok));
      underflow    <= ~clear & (underflow | (rd_en & ~pop_ok));
    end
endmodule
